instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
- Consumes the one-hot phase strobes (fetch/decode/execute/commit) from instruction_phase_decoder.
- Owns the program counter and issues instruction reads to program memory, with wait-state support.
- Holds the fetched word stable in the instruction register through decode/execute, then advances or loads the PC on commit.
- Exports a stall so the phase sequencer can freeze on slow memory.

Parameters:
- ADDR_WIDTH, 16, program address / PC width.
- DATA_WIDTH, 16, instruction word width.
- RESET_VECTOR, 16'h0000, PC value after reset.
- TIMEOUT_CYCLES, 16, wait-state limit; used only with the optional feature.
- NOP_OPCODE, 16'h0000, word substituted into the IR on a fetch timeout.

Ports:
- clk  in  1  system clock, all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- fetch  in  1  fetch-phase strobe.
- decode  in  1  decode-phase strobe; unused internally, kept for phase-alignment checks.
- execute  in  1  execute-phase strobe; unused internally.
- commit  in  1  commit-phase strobe.
- pc_load  in  1  on commit, load PC from pc_load_value instead of incrementing.
- pc_load_value  in  ADDR_WIDTH  jump/branch target.
- mem_addr  out  ADDR_WIDTH  program memory address; always equals pc.
- mem_rd  out  1  read request, combinational.
- mem_rdata  in  DATA_WIDTH  read data, valid when mem_ready=1.
- mem_ready  in  1  memory accepts/returns the read this cycle.
- stall  out  1  high while a read is outstanding and not ready.
- instr  out  DATA_WIDTH  instruction register.
- instr_valid  out  1  instr holds a valid fetched word.
- pc  out  ADDR_WIDTH  address of the current instruction.
- fetch_fault  out  1  sticky timeout flag; tied 0 when the feature is absent.

Behaviour:
- Reset (sync, active-high, dominates all inputs):
  - pc=RESET_VECTOR, instr=0, instr_valid=0, fetch_fault=0, state=IDLE.
  - Combinational outputs follow: mem_rd=0, stall=0.
- Combinational outputs:
  - mem_rd = (state==IDLE & fetch) | (state==WAIT).
  - stall = mem_rd & ~mem_ready.
  - mem_addr = pc.
- IDLE:
  - fetch & mem_ready: instr<=mem_rdata, instr_valid<=1, go to HOLD. Zero-wait memory gives instr valid in the decode cycle, one cycle after fetch.
  - fetch & ~mem_ready: go to WAIT.
  - commit, mem_ready or pc_load without fetch: ignored.
- WAIT:
  - mem_rd held at 1.
  - First cycle with mem_ready=1: capture instr, instr_valid<=1, go to HOLD.
  - fetch or commit here: ignored.
- HOLD:
  - instr and pc are frozen.
  - commit: pc <= pc_load ? pc_load_value : pc+1, with wrap modulo 2^ADDR_WIDTH (0xFFFF+1 = 0x0000). Also instr_valid<=0, go to IDLE.
  - instr keeps its last value after commit.
  - fetch & commit in the same cycle: commit wins, fetch is dropped.
  - fetch alone: ignored.
- pc_load is sampled only in a HOLD cycle with commit=1.
- Reset mid-WAIT: mem_rd falls in the same cycle as reset takes effect, because state becomes IDLE; the pending read is abandoned.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entry to WAIT and increments each WAIT cycle with mem_ready=0.
  - When the counter reaches TIMEOUT_CYCLES: instr<=NOP_OPCODE, instr_valid<=1, fetch_fault<=1, go to HOLD.
  - fetch_fault stays set until reset.
- Undefined: WAIT persists indefinitely, there is no counter logic, and fetch_fault is constant 0.

Decomposition:
- Shared package fetch_pkg holds:
  - the fetch_state_t enum {IDLE, WAIT, HOLD};
  - default ADDR_WIDTH and DATA_WIDTH;
  - the NOP_OPCODE and RESET_VECTOR constants.
- One sub-module, program_counter: PC register with sync reset, load and increment-with-wrap.

Test Plan:
- Reset: assert reset 1 cycle, then release -> pc=0x0000, instr_valid=0, mem_rd=0, stall=0.
- Zero-wait: mem_ready=1, mem[0]=0x1234, fetch strobe -> mem_rd=1 with mem_addr=0x0000 in the fetch cycle; instr=0x1234 and instr_valid=1 in the decode cycle; after commit, pc=0x0001.
- Wait states: ready low in the fetch cycle and the 2 following cycles, high on the 3rd -> stall=1 for exactly 3 cycles; instr_valid rises the cycle after ready.
- Jump and wrap:
  - commit with pc_load=1, pc_load_value=0x0ABC -> next mem_addr=0x0ABC.
  - pc=0xFFFF with a plain commit -> pc=0x0000.
- Reset mid-WAIT: reset during the 2nd wait cycle -> state IDLE and mem_rd=0 from the reset cycle; instr_valid=0; pc=RESET_VECTOR.
- Timeout (FETCH_TIMEOUT_EN defined): mem_ready held 0 -> after 16 wait cycles, instr=0x0000, instr_valid=1, fetch_fault=1; fetch_fault still 1 after the next commit.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch unit and its program counter.
// Holds the fetch FSM state encoding plus reset/NOP constants.
package fetch_pkg;

    localparam int FETCH_ADDR_WIDTH = 16;
    localparam int FETCH_DATA_WIDTH = 16;

    localparam logic [FETCH_ADDR_WIDTH-1:0] FETCH_RESET_VECTOR = 16'h0000;
    localparam logic [FETCH_DATA_WIDTH-1:0] FETCH_NOP_OPCODE   = 16'h0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/program_counter.sv
// Program counter: synchronous reset, load from a target or increment with wrap.
// One-cycle update on advance_i; no backpressure, the caller decides when to advance.
module program_counter
    import fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = FETCH_ADDR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = FETCH_RESET_VECTOR
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  advance_i,
    input  logic                  load_i,
    input  logic [ADDR_WIDTH-1:0] load_value_i,
    output logic [ADDR_WIDTH-1:0] pc_o
);

    logic [ADDR_WIDTH-1:0] pc_q;
    logic [ADDR_WIDTH-1:0] pc_d;

    // Increment relies on natural truncation for the all-ones to zero wrap.
    always_comb begin
        pc_d = pc_q;
        if (advance_i) begin
            pc_d = load_i ? load_value_i : pc_q + ADDR_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_VECTOR;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch unit: reads program memory on the fetch strobe, holds the word in the IR until commit.
// Optional wait-state timeout with sticky fault under macro FETCH_TIMEOUT_EN.
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH     = FETCH_ADDR_WIDTH,
    parameter int                    DATA_WIDTH     = FETCH_DATA_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR   = FETCH_RESET_VECTOR,
    parameter int                    TIMEOUT_CYCLES = 16,
    parameter logic [DATA_WIDTH-1:0] NOP_OPCODE     = FETCH_NOP_OPCODE
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fetch,
    input  logic                  decode,
    input  logic                  execute,
    input  logic                  commit,
    input  logic                  pc_load,
    input  logic [ADDR_WIDTH-1:0] pc_load_value,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ready,
    output logic                  stall,
    output logic [DATA_WIDTH-1:0] instr,
    output logic                  instr_valid,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  fetch_fault
);

    fetch_state_t          state_q, state_d;
    logic [DATA_WIDTH-1:0] instr_q, instr_d;
    logic                  instr_valid_q, instr_valid_d;
    logic                  pc_advance;

`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             fault_q, fault_d;
`endif

    always_comb begin
        state_d       = state_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        pc_advance    = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        wait_cnt_d    = wait_cnt_q;
        fault_d       = fault_q;
`endif
        case (state_q)
            IDLE: begin
                if (fetch) begin
                    if (mem_ready) begin
                        instr_d       = mem_rdata;
                        instr_valid_d = 1'b1;
                        state_d       = HOLD;
                    end else begin
                        state_d = WAIT;
`ifdef FETCH_TIMEOUT_EN
                        wait_cnt_d = '0;
`endif
                    end
                end
            end
            WAIT: begin
                if (mem_ready) begin
                    instr_d       = mem_rdata;
                    instr_valid_d = 1'b1;
                    state_d       = HOLD;
                end
`ifdef FETCH_TIMEOUT_EN
                // The cycle that would make the count reach the limit retires the fetch as a NOP.
                else if (wait_cnt_q == CNT_LAST) begin
                    instr_d       = NOP_OPCODE;
                    instr_valid_d = 1'b1;
                    fault_d       = 1'b1;
                    state_d       = HOLD;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
`endif
            end
            HOLD: begin
                if (commit) begin
                    pc_advance    = 1'b1;
                    instr_valid_d = 1'b0;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            wait_cnt_q    <= '0;
            fault_q       <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
`ifdef FETCH_TIMEOUT_EN
            wait_cnt_q    <= wait_cnt_d;
            fault_q       <= fault_d;
`endif
        end
    end

    program_counter #(
        .ADDR_WIDTH   (ADDR_WIDTH),
        .RESET_VECTOR (RESET_VECTOR)
    ) u_pc (
        .clk          (clk),
        .reset        (reset),
        .advance_i    (pc_advance),
        .load_i       (pc_load),
        .load_value_i (pc_load_value),
        .pc_o         (pc)
    );

    // Reset drops the request in the reset cycle itself, abandoning any pending read.
    assign mem_rd      = ~reset & (((state_q == IDLE) & fetch) | (state_q == WAIT));
    assign stall       = mem_rd & ~mem_ready;
    assign mem_addr    = pc;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;

`ifdef FETCH_TIMEOUT_EN
    assign fetch_fault = fault_q;

    logic unused_ok;
    assign unused_ok = &{1'b0, decode, execute};
`else
    assign fetch_fault = 1'b0;

    logic unused_ok;
    assign unused_ok = &{1'b0, decode, execute, TIMEOUT_CYCLES[0]};
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: vector table plus hand sequences for reset and timeout.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch, decode, execute, commit, pc_load;
    logic [15:0] pc_load_value;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [15:0] mem_rdata;
    logic        mem_ready;
    logic        stall;
    logic [15:0] instr;
    logic        instr_valid;
    logic [15:0] pc;
    logic        fetch_fault;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instruction_fetch_unit dut (
        .clk           (clk),
        .reset         (reset),
        .fetch         (fetch),
        .decode        (decode),
        .execute       (execute),
        .commit        (commit),
        .pc_load       (pc_load),
        .pc_load_value (pc_load_value),
        .mem_addr      (mem_addr),
        .mem_rd        (mem_rd),
        .mem_rdata     (mem_rdata),
        .mem_ready     (mem_ready),
        .stall         (stall),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .pc            (pc),
        .fetch_fault   (fetch_fault)
    );

    typedef struct {
        logic        rst, fch, cmt, ld;
        logic [15:0] ldv;
        logic        rdy;
        logic [15:0] rdata;
        logic        e_rd, e_stall;
        logic [15:0] e_addr;
        logic [15:0] e_pc, e_instr;
        logic        e_ivld;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rst, input logic fch, input logic cmt, input logic ld,
                                input logic [15:0] ldv, input logic rdy, input logic [15:0] rdata,
                                input logic e_rd, input logic e_stall, input logic [15:0] e_addr,
                                input logic [15:0] e_pc, input logic [15:0] e_instr, input logic e_ivld);
        vec_t v;
        v.rst = rst; v.fch = fch; v.cmt = cmt; v.ld = ld; v.ldv = ldv;
        v.rdy = rdy; v.rdata = rdata;
        v.e_rd = e_rd; v.e_stall = e_stall; v.e_addr = e_addr;
        v.e_pc = e_pc; v.e_instr = e_instr; v.e_ivld = e_ivld;
        return v;
    endfunction

    // Drive at the falling edge, check combinational outputs, then registered outputs after the edge.
    task automatic drive(input logic rst, input logic fch, input logic cmt, input logic ld,
                         input logic [15:0] ldv, input logic rdy, input logic [15:0] rdata);
        @(negedge clk);
        reset = rst; fetch = fch; commit = cmt; pc_load = ld;
        pc_load_value = ldv; mem_ready = rdy; mem_rdata = rdata;
        #1;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        string tag;
        tag = $sformatf("v%0d", idx);
        drive(v.rst, v.fch, v.cmt, v.ld, v.ldv, v.rdy, v.rdata);
        chk({tag, ".mem_rd"},   {31'd0, mem_rd}, {31'd0, v.e_rd});
        chk({tag, ".stall"},    {31'd0, stall},  {31'd0, v.e_stall});
        chk({tag, ".mem_addr"}, {16'd0, mem_addr}, {16'd0, v.e_addr});
        @(posedge clk);
        #1;
        chk({tag, ".pc"},          {16'd0, pc},    {16'd0, v.e_pc});
        chk({tag, ".instr"},       {16'd0, instr}, {16'd0, v.e_instr});
        chk({tag, ".instr_valid"}, {31'd0, instr_valid}, {31'd0, v.e_ivld});
        chk({tag, ".fetch_fault"}, {31'd0, fetch_fault}, 32'd0);
    endtask

    initial begin
        reset = 1'b0; fetch = 1'b0; decode = 1'b0; execute = 1'b0; commit = 1'b0;
        pc_load = 1'b0; pc_load_value = 16'h0; mem_ready = 1'b0; mem_rdata = 16'h0;

        //           rst fch cmt ld  ldv      rdy rdata     rd st addr     pc       instr    iv
        vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 1, 16'h1234, 1, 0, 16'h0000, 16'h0000, 16'h1234, 1));
        vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h1234, 1));
        vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 1, 16'hFFFF, 0, 0, 16'h0000, 16'h0000, 16'h1234, 1));
        vecs.push_back(mk(0, 0, 1, 0, 16'h0000, 1, 16'h0000, 0, 0, 16'h0000, 16'h0001, 16'h1234, 0));
        vecs.push_back(mk(0, 0, 1, 1, 16'h0500, 1, 16'h0000, 0, 0, 16'h0001, 16'h0001, 16'h1234, 0));
        vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 0, 16'h0000, 1, 1, 16'h0001, 16'h0001, 16'h1234, 0));
        vecs.push_back(mk(0, 1, 1, 0, 16'h0000, 0, 16'h0000, 1, 1, 16'h0001, 16'h0001, 16'h1234, 0));
        vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 16'h0000, 1, 1, 16'h0001, 16'h0001, 16'h1234, 0));
        vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 16'hBEEF, 1, 0, 16'h0001, 16'h0001, 16'hBEEF, 1));
        vecs.push_back(mk(0, 1, 1, 1, 16'h0ABC, 1, 16'h0000, 0, 0, 16'h0001, 16'h0ABC, 16'hBEEF, 0));
        vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 1, 16'h5555, 1, 0, 16'h0ABC, 16'h0ABC, 16'h5555, 1));
        vecs.push_back(mk(0, 0, 1, 1, 16'hFFFF, 1, 16'h0000, 0, 0, 16'h0ABC, 16'hFFFF, 16'h5555, 0));
        vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 1, 16'h7777, 1, 0, 16'hFFFF, 16'hFFFF, 16'h7777, 1));
        vecs.push_back(mk(0, 0, 1, 0, 16'h0000, 1, 16'h0000, 0, 0, 16'hFFFF, 16'h0000, 16'h7777, 0));
        vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 1, 16'h1111, 1, 0, 16'h0000, 16'h0000, 16'h1111, 1));
        vecs.push_back(mk(0, 0, 1, 0, 16'h0000, 1, 16'h0000, 0, 0, 16'h0000, 16'h0001, 16'h1111, 0));
        vecs.push_back(mk(0, 1, 0, 0, 16'h0000, 0, 16'h0000, 1, 1, 16'h0001, 16'h0001, 16'h1111, 0));
        vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 16'h0000, 1, 1, 16'h0001, 16'h0001, 16'h1111, 0));
        vecs.push_back(mk(1, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0001, 16'h0000, 16'h0000, 0));
        vecs.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0));

        // Reset dominates a simultaneous fetch with ready memory.
        drive(1, 1, 0, 0, 16'h0, 1, 16'hDEAD);
        chk("rst.mem_rd", {31'd0, mem_rd}, 32'd0);
        chk("rst.stall",  {31'd0, stall},  32'd0);
        @(posedge clk);
        #1;
        chk("rst.pc",          {16'd0, pc},    32'd0);
        chk("rst.instr",       {16'd0, instr}, 32'd0);
        chk("rst.instr_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst.fetch_fault", {31'd0, fetch_fault}, 32'd0);
        drive(0, 0, 0, 0, 16'h0, 0, 16'h0);
        chk("idle.mem_rd", {31'd0, mem_rd}, 32'd0);
        chk("idle.stall",  {31'd0, stall},  32'd0);
        @(posedge clk);

        foreach (vecs[i]) run_vec(i, vecs[i]);

        // Load a non-zero word, commit (pc 0 -> 1), then start a fetch that never gets ready.
        drive(0, 1, 0, 0, 16'h0, 1, 16'hABCD);
        @(posedge clk);
        drive(0, 0, 1, 0, 16'h0, 1, 16'h0);
        @(posedge clk);
        #1;
        chk("pre_to.pc", {16'd0, pc}, 32'h1);
        drive(0, 1, 0, 0, 16'h0, 0, 16'h0);
        @(posedge clk);
`ifdef FETCH_TIMEOUT_EN
        for (int k = 1; k <= 16; k++) begin
            drive(0, 0, 0, 0, 16'h0, 0, 16'h0);
            chk($sformatf("to%0d.stall", k), {31'd0, stall}, 32'd1);
            @(posedge clk);
            #1;
            chk($sformatf("to%0d.instr_valid", k), {31'd0, instr_valid}, (k == 16) ? 32'd1 : 32'd0);
            chk($sformatf("to%0d.fetch_fault", k), {31'd0, fetch_fault}, (k == 16) ? 32'd1 : 32'd0);
        end
        chk("to.instr", {16'd0, instr}, 32'h0000);
        drive(0, 0, 1, 0, 16'h0, 0, 16'h0);
        chk("to_hold.mem_rd", {31'd0, mem_rd}, 32'd0);
        @(posedge clk);
        #1;
        chk("to_commit.pc",          {16'd0, pc}, 32'h2);
        chk("to_commit.instr_valid", {31'd0, instr_valid}, 32'd0);
        chk("to_commit.fetch_fault", {31'd0, fetch_fault}, 32'd1);
`else
        for (int k = 1; k <= 20; k++) begin
            drive(0, 0, 0, 0, 16'h0, 0, 16'h0);
            chk($sformatf("w%0d.stall", k), {31'd0, stall}, 32'd1);
            @(posedge clk);
            #1;
            chk($sformatf("w%0d.instr_valid", k), {31'd0, instr_valid}, 32'd0);
            chk($sformatf("w%0d.fetch_fault", k), {31'd0, fetch_fault}, 32'd0);
        end
        chk("w.instr", {16'd0, instr}, 32'hABCD);
        drive(0, 0, 0, 0, 16'h0, 1, 16'h4321);
        chk("w_rdy.stall", {31'd0, stall}, 32'd0);
        @(posedge clk);
        #1;
        chk("w_rdy.instr",       {16'd0, instr}, 32'h4321);
        chk("w_rdy.instr_valid", {31'd0, instr_valid}, 32'd1);
        chk("w_rdy.fetch_fault", {31'd0, fetch_fault}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
